// File: rtl/serial_signed_pow2_divider.sv
// serial_signed_pow2_divider
//   Signed divide of an N-bit two's-complement dividend by 2^s, one arithmetic
//   right shift per clock. mode=0 gives floor (plain arithmetic shift), mode=1
//   gives C-style truncation toward zero. Valid/ready handshake on both sides.
//
// Parameters
//   N   data width (N >= 2)
//   SW  shift-amount width, $clog2(N)
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-low reset
//   in_valid   upstream offers a/s/mode
//   in_ready   block can accept a transaction
//   a          signed dividend
//   s          shift amount (divisor 2^s); values above N-1 saturate to N-1
//   mode       0 = floor, 1 = truncate toward zero
//   out_valid  res/inexact valid
//   out_ready  downstream accepts result
//   res        signed quotient (register-driven)
//   inexact    at least one 1-bit was shifted out
//
// Build option
//   SERIAL_POW2_DIV_BACK_TO_BACK_EN: when defined, in_ready follows out_ready
//   in DONE so a result handshake and a new accept can share one edge.
//   Undefined: in_ready=0 in DONE and an IDLE cycle follows every handshake.

module serial_signed_pow2_divider #(
  parameter int unsigned N  = 8,
  parameter int unsigned SW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  a,
  input  logic [SW-1:0] s,
  input  logic          mode,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  res,
  output logic          inexact
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state, state_n;
  logic [N-1:0]  work, work_n;
  logic [SW-1:0] count, count_n;
  logic          sticky, sticky_n;
  logic          mode_q, mode_n;
  logic [N-1:0]  res_q, res_n;
  logic          inexact_q, inexact_n;
  logic          in_ready_q, in_ready_n;
  logic          out_valid_q, out_valid_n;

  logic [SW-1:0] s_sat;
  logic [N-1:0]  shifted;
  logic          sticky_next;
  logic          load;

  // Saturate the shift amount only when SW can encode values above N-1
  generate
    if ((64'd1 << SW) > 64'(N)) begin : g_sat
      always_comb begin
        s_sat = (s > SW'(N - 1)) ? SW'(N - 1) : s;
      end
    end else begin : g_nosat
      always_comb begin
        s_sat = s;
      end
    end
  endgenerate

  // One-bit arithmetic shift and the sticky bit it would produce
  assign shifted     = {work[N-1], work[N-1:1]};
  assign sticky_next = sticky | work[0];

  // In DONE the back-to-back build lets the downstream ready gate a new accept
`ifdef SERIAL_POW2_DIV_BACK_TO_BACK_EN
  assign in_ready = (state == DONE) ? out_ready : in_ready_q;
`else
  assign in_ready = in_ready_q;
`endif

  assign out_valid = out_valid_q;
  assign res       = res_q;
  assign inexact   = inexact_q;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      work        <= '0;
      count       <= '0;
      sticky      <= 1'b0;
      mode_q      <= 1'b0;
      res_q       <= '0;
      inexact_q   <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state       <= state_n;
      work        <= work_n;
      count       <= count_n;
      sticky      <= sticky_n;
      mode_q      <= mode_n;
      res_q       <= res_n;
      inexact_q   <= inexact_n;
      in_ready_q  <= in_ready_n;
      out_valid_q <= out_valid_n;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_n     = state;
    work_n      = work;
    count_n     = count;
    sticky_n    = sticky;
    mode_n      = mode_q;
    res_n       = res_q;
    inexact_n   = inexact_q;
    in_ready_n  = in_ready_q;
    out_valid_n = out_valid_q;
    load        = 1'b0;

    unique case (state)
      IDLE: begin
        in_ready_n  = 1'b1;
        out_valid_n = 1'b0;
        if (in_valid) begin
          load = 1'b1;
        end
      end

      SHIFT: begin
        work_n   = shifted;
        sticky_n = sticky_next;
        count_n  = count - SW'(1);
        if (count == SW'(1)) begin
          // Truncation only moves negative inexact quotients up by one
          if (mode_q && shifted[N-1] && sticky_next) begin
            res_n = shifted + N'(1);
          end else begin
            res_n = shifted;
          end
          inexact_n   = sticky_next;
          out_valid_n = 1'b1;
          state_n     = DONE;
        end
      end

      DONE: begin
        if (out_ready) begin
          state_n     = IDLE;
          out_valid_n = 1'b0;
          in_ready_n  = 1'b1;
`ifdef SERIAL_POW2_DIV_BACK_TO_BACK_EN
          if (in_valid) begin
            load = 1'b1;
          end
`endif
        end
      end

      default: begin
        state_n     = IDLE;
        in_ready_n  = 1'b1;
        out_valid_n = 1'b0;
      end
    endcase

    // Accept a new transaction; s==0 completes on the accepting edge
    if (load) begin
      work_n     = a;
      mode_n     = mode;
      sticky_n   = 1'b0;
      in_ready_n = 1'b0;
      if (s_sat == '0) begin
        count_n     = '0;
        res_n       = a;
        inexact_n   = 1'b0;
        out_valid_n = 1'b1;
        state_n     = DONE;
      end else begin
        count_n     = s_sat;
        out_valid_n = 1'b0;
        state_n     = SHIFT;
      end
    end
  end

endmodule

// File: tb/tb_serial_signed_pow2_divider.sv
// Directed self-checking bench for serial_signed_pow2_divider (N=8).
module tb_serial_signed_pow2_divider;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [2:0] s;
  logic       mode;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] res;
  logic       inexact;

  int checks = 0;
  int errors = 0;

  serial_signed_pow2_divider #(.N(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .s         (s),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res),
    .inexact   (inexact)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Vector tables: dividend, shift, mode, expected quotient, expected inexact
  localparam int NV = 10;
  localparam logic [7:0] VA [NV] = '{8'hE9, 8'h81, 8'h17, 8'h40, 8'hE9, 8'hF0, 8'h80, 8'h81, 8'h17, 8'h7F};
  localparam logic [2:0] VS [NV] = '{3'd3,  3'd7,  3'd3,  3'd2,  3'd3,  3'd4,  3'd7,  3'd7,  3'd3,  3'd7};
  localparam logic       VM [NV] = '{1'b0,  1'b0,  1'b0,  1'b0,  1'b1,  1'b1,  1'b1,  1'b1,  1'b1,  1'b1};
  localparam logic [7:0] VR [NV] = '{8'hFD, 8'hFF, 8'h02, 8'h10, 8'hFE, 8'hFF, 8'hFF, 8'h00, 8'h02, 8'h00};
  localparam logic       VX [NV] = '{1'b1,  1'b1,  1'b1,  1'b0,  1'b1,  1'b0,  1'b0,  1'b1,  1'b1,  1'b1};

  // Drive one transaction with out_ready=1; report result and edges from accept to out_valid
  task automatic run_txn(input logic [7:0] ta, input logic [2:0] ts, input logic tm,
                         output logic [7:0] r, output logic ix, output int lat);
    int n;
    @(negedge clk);
    a = ta; s = ts; mode = tm; in_valid = 1'b1; out_ready = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    r  = res;
    ix = inexact;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; s = '0; mode = 1'b0;
    #12;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || res !== 8'h00 || inexact !== 1'b0) begin
      errors++;
      $display("FAIL reset: in_ready=%b out_valid=%b res=%h inexact=%b, required 1 0 00 0",
               in_ready, out_valid, res, inexact);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_vectors();
    logic [7:0] r;
    logic       ix;
    int         lat;
    for (int i = 0; i < NV; i++) begin
      run_txn(VA[i], VS[i], VM[i], r, ix, lat);
      checks++;
      if (r !== VR[i] || ix !== VX[i] || lat != int'(VS[i])) begin
        errors++;
        $display("FAIL vector%0d a=%h s=%0d mode=%b: res=%h inexact=%b latency=%0d, required res=%h inexact=%b latency=%0d",
                 i, VA[i], VS[i], VM[i], r, ix, lat, VR[i], VX[i], VS[i]);
      end
    end
  endtask

  task automatic test_zero_shift();
    logic [7:0] r;
    logic       ix;
    int         lat;
    run_txn(8'h7F, 3'd0, 1'b1, r, ix, lat);
    checks++;
    if (r !== 8'h7F || ix !== 1'b0 || lat != 0) begin
      errors++;
      $display("FAIL zero_shift: res=%h inexact=%b latency=%0d, required 7f 0 0", r, ix, lat);
    end
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL zero_shift_idle: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    int last = -1;
    int done_cnt = 0;
    @(negedge clk);
    a = 8'h7F; s = 3'd0; mode = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid) begin
        checks++;
        if (res !== 8'h7F || inexact !== 1'b0) begin
          errors++;
          $display("FAIL b2b_result: res=%h inexact=%b, required 7f 0", res, inexact);
        end
        if (last >= 0) begin
          checks++;
`ifdef SERIAL_POW2_DIV_BACK_TO_BACK_EN
          if (i - last > 2) begin
            errors++;
            $display("FAIL b2b_interval: %0d cycles, required at most 2", i - last);
          end
`else
          if (i - last != 2) begin
            errors++;
            $display("FAIL b2b_interval: %0d cycles, required 2", i - last);
          end
`endif
        end
        last = i;
        done_cnt++;
      end
    end
    in_valid = 1'b0;
    checks++;
    if (done_cnt < 5) begin
      errors++;
      $display("FAIL b2b_count: %0d completions in 12 cycles, required at least 5", done_cnt);
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int n = 0;
    @(negedge clk);
    a = 8'hE9; s = 3'd3; mode = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_wait: out_valid=%b, required 1", out_valid);
    end
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        a = 8'h00; s = 3'd0; mode = 1'b0; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      checks++;
      if (res !== 8'hFE || inexact !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold%0d: res=%h inexact=%b in_ready=%b out_valid=%b, required fe 1 0 1",
                 i, res, inexact, in_ready, out_valid);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || res !== 8'hFE) begin
      errors++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b res=%h, required 0 1 fe", out_valid, in_ready, res);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] r;
    logic       ix;
    int         lat;
    @(negedge clk);
    a = 8'hE9; s = 3'd3; mode = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || res !== 8'h00 || in_ready !== 1'b1 || inexact !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: out_valid=%b res=%h in_ready=%b inexact=%b, required 0 00 1 0",
               out_valid, res, in_ready, inexact);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    run_txn(8'hE9, 3'd3, 1'b0, r, ix, lat);
    checks++;
    if (r !== 8'hFD || ix !== 1'b1 || lat != 3) begin
      errors++;
      $display("FAIL reset_recover: res=%h inexact=%b latency=%0d, required fd 1 3", r, ix, lat);
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_zero_shift();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
